// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
// Receives a program image as a byte stream (16-bit word count, then words low byte first),
// writes each assembled little-endian word to sequential word addresses starting at BASE_ADDR,
// and holds the core in reset until the image has fully loaded.
// Optional build macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_loader #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    output logic        o_rx_ready,
    output logic        o_we,
    output logic [31:0] o_addr,
    output logic [31:0] o_wdata,
    output logic        o_core_hold,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    // Explicit encodings keep the remaining states stable when CSUM is compiled out.
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLen0  = 3'd1,
        StLen1  = 3'd2,
        StData  = 3'd3,
        StWrite = 3'd4,
`ifdef IMEM_LOADER_CHECKSUM_EN
        StCsum  = 3'd5,
`endif
        StDone  = 3'd6,
        StErr   = 3'd7
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [15:0] r_len;
    logic [15:0] r_widx;
    logic [1:0]  r_bidx;
    logic [23:0] r_word;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  r_csum;
`endif

    logic        w_accept;
    logic        w_restart;
    logic [15:0] w_len_full;
    logic        w_len_too_big;
    logic        w_last_word;
    logic [31:0] w_word_addr;

    // Handshake and outputs are decoded purely from the state register.
    always_comb begin
        o_rx_ready = 1'b0;
        o_busy     = 1'b0;
        o_we       = 1'b0;
        o_done     = 1'b0;
        o_err      = 1'b0;
        unique case (r_state)
            StLen0, StLen1, StData: begin
                o_rx_ready = 1'b1;
                o_busy     = 1'b1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            StCsum: begin
                o_rx_ready = 1'b1;
                o_busy     = 1'b1;
            end
`endif
            StWrite: begin
                o_we   = 1'b1;
                o_busy = 1'b1;
            end
            StDone:  o_done = 1'b1;
            StErr:   o_err  = 1'b1;
            default: ;
        endcase
    end

    assign o_core_hold = (r_state != StDone);
    assign o_addr      = r_addr;
    assign o_wdata     = r_wdata;

    assign w_accept      = i_rx_valid && o_rx_ready;
    assign w_restart     = i_start &&
                           (r_state == StIdle || r_state == StDone || r_state == StErr);
    assign w_len_full    = {i_rx_data, r_len[7:0]};
    assign w_len_too_big = {16'h0000, w_len_full} > DEPTH_WORDS;
    assign w_last_word   = (r_widx == r_len - 16'd1);
    // Address arithmetic wraps at 32 bits by construction.
    assign w_word_addr   = BASE_ADDR + {14'h0000, r_widx, 2'b00};

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (i_start) w_state_next = StLen0;
            end
            StLen0: begin
                if (w_accept) w_state_next = StLen1;
            end
            StLen1: begin
                if (w_accept) begin
                    if (w_len_too_big) begin
                        w_state_next = StErr;
                    end else if (w_len_full == 16'h0000) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        w_state_next = StCsum;
`else
                        w_state_next = StDone;
`endif
                    end else begin
                        w_state_next = StData;
                    end
                end
            end
            StData: begin
                if (w_accept && r_bidx == 2'd3) w_state_next = StWrite;
            end
            StWrite: begin
                if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_state_next = StCsum;
`else
                    w_state_next = StDone;
`endif
                end else begin
                    w_state_next = StData;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            StCsum: begin
                if (w_accept) w_state_next = (i_rx_data == r_csum) ? StDone : StErr;
            end
`endif
            StDone, StErr: begin
                if (i_start) w_state_next = StLen0;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Datapath: length capture, byte-lane assembly, write address/data registers, word index.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_len   <= 16'h0000;
            r_widx  <= 16'h0000;
            r_bidx  <= 2'd0;
            r_word  <= 24'h000000;
            r_addr  <= 32'h0000_0000;
            r_wdata <= 32'h0000_0000;
        end else begin
            if (w_restart) begin
                r_widx <= 16'h0000;
                r_bidx <= 2'd0;
            end
            unique case (r_state)
                StLen0: if (w_accept) r_len[7:0] <= i_rx_data;
                StLen1: if (w_accept) r_len[15:8] <= i_rx_data;
                StData: begin
                    if (w_accept) begin
                        r_bidx <= 2'(r_bidx + 2'd1);
                        unique case (r_bidx)
                            2'd0: r_word[7:0]   <= i_rx_data;
                            2'd1: r_word[15:8]  <= i_rx_data;
                            2'd2: r_word[23:16] <= i_rx_data;
                            2'd3: begin
                                r_wdata <= {i_rx_data, r_word};
                                r_addr  <= w_word_addr;
                            end
                            default: ;
                        endcase
                    end
                end
                StWrite: r_widx <= r_widx + 16'd1;
                default: ;
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR over every accepted data byte; cleared on each new load.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_csum <= 8'h00;
        end else if (w_restart) begin
            r_csum <= 8'h00;
        end else if (r_state == StData && w_accept) begin
            r_csum <= r_csum ^ i_rx_data;
        end
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (default parameters).
// Honours IMEM_LOADER_CHECKSUM_EN so the same bench covers both builds.
module tb_imem_loader;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_rx_valid = 1'b0;
    logic [7:0]  i_rx_data = 8'h00;
    logic        o_rx_ready;
    logic        o_we;
    logic [31:0] o_addr;
    logic [31:0] o_wdata;
    logic        o_core_hold;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    int checks = 0;
    int failures = 0;

    logic [31:0] wa[$];
    logic [31:0] wd[$];
    int          nacc = 0;
    int          nbad = 0;

    imem_loader dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_rx_valid  (i_rx_valid),
        .i_rx_data   (i_rx_data),
        .o_rx_ready  (o_rx_ready),
        .o_we        (o_we),
        .o_addr      (o_addr),
        .o_wdata     (o_wdata),
        .o_core_hold (o_core_hold),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    always #5 i_clk = ~i_clk;

    // Observe writes and accepted bytes mid-cycle, away from the active edge.
    always @(negedge i_clk) begin
        if (o_we) begin
            wa.push_back(o_addr);
            wd.push_back(o_wdata);
        end
        if (i_rx_valid && o_rx_ready) nacc++;
        if (o_we && o_rx_ready) nbad++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    // Present one byte until the loader takes it; optional idle cycle before it.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        if (gap) begin
            i_rx_valid = 1'b0;
            tick();
        end
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        n = 0;
        while (!o_rx_ready && n < 20) begin
            tick();
            n++;
        end
        chk("rx_ready_wait", {31'd0, o_rx_ready}, 32'd1);
        tick();
        i_rx_valid = 1'b0;
    endtask

    task automatic send_img(input logic [7:0] img[$], input bit gap);
        foreach (img[i]) send_byte(img[i], gap);
    endtask

    function automatic logic [7:0] img_csum(input logic [7:0] img[$]);
        logic [7:0] x = 8'h00;
        for (int i = 2; i < img.size(); i++) x = x ^ img[i];
        return x;
    endfunction

    task automatic wait_end();
        int n = 0;
        while (!o_done && !o_err && n < 20) begin
            tick();
            n++;
        end
        chk("end_wait", {31'd0, (o_done | o_err)}, 32'd1);
    endtask

    initial begin
        logic [7:0] img[$];
        int w0;
        int a0;

        // Reset and idle.
        repeat (2) tick();
        i_rst = 1'b0;
        repeat (10) tick();
        chk("rst_hold", {31'd0, o_core_hold}, 32'd1);
        chk("rst_ready", {31'd0, o_rx_ready}, 32'd0);
        chk("rst_we", {31'd0, o_we}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        chk("rst_err", {31'd0, o_err}, 32'd0);
        chk("rst_addr", o_addr, 32'h0);
        chk("rst_wdata", o_wdata, 32'h0);
        chk("idle_no_accept", nacc, 32'd0);

        // Two-word image, continuous valid.
        pulse_start();
        chk("start_ready", {31'd0, o_rx_ready}, 32'd1);
        chk("start_busy", {31'd0, o_busy}, 32'd1);
        send_img('{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00}, 1'b0);
        chk("lat_we", {31'd0, o_we}, 32'd1);
        chk("lat_addr", o_addr, 32'h0000_0000);
        chk("lat_wdata", o_wdata, 32'h00A0_0513);
        chk("lat_ready_low", {31'd0, o_rx_ready}, 32'd0);
        tick();
        chk("lat_ready_back", {31'd0, o_rx_ready}, 32'd1);
        chk("lat_we_one", {31'd0, o_we}, 32'd0);
        img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        send_img('{8'h93, 8'h05, 8'h10, 8'h00}, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(img_csum(img), 1'b0);
`endif
        wait_end();
        chk("img1_nw", wa.size(), 32'd2);
        chk("img1_a0", wa[0], 32'h0);
        chk("img1_d0", wd[0], 32'h00A0_0513);
        chk("img1_a1", wa[1], 32'h4);
        chk("img1_d1", wd[1], 32'h0010_0593);
        chk("img1_done", {31'd0, o_done}, 32'd1);
        chk("img1_hold", {31'd0, o_core_hold}, 32'd0);
        chk("img1_busy", {31'd0, o_busy}, 32'd0);
        chk("img1_hold_addr", o_addr, 32'h4);

        // Same image, valid toggled; restart from DONE.
        w0 = wa.size();
        a0 = nacc;
        pulse_start();
        chk("rs_done_clr", {31'd0, o_done}, 32'd0);
        chk("rs_hold", {31'd0, o_core_hold}, 32'd1);
        chk("rs_ready", {31'd0, o_rx_ready}, 32'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        img.push_back(img_csum(img));
`endif
        send_img(img, 1'b1);
        wait_end();
        chk("tog_nw", wa.size() - w0, 32'd2);
        chk("tog_d0", wd[w0], 32'h00A0_0513);
        chk("tog_a1", wa[w0+1], 32'h4);
        chk("tog_d1", wd[w0+1], 32'h0010_0593);
        chk("tog_nacc", nacc - a0, img.size());
        chk("tog_done", {31'd0, o_done}, 32'd1);

        // Oversized length goes to ERR right after the second byte.
        w0 = wa.size();
        pulse_start();
        send_img('{8'h41, 8'h00}, 1'b0);
        chk("big_err", {31'd0, o_err}, 32'd1);
        chk("big_hold", {31'd0, o_core_hold}, 32'd1);
        chk("big_ready", {31'd0, o_rx_ready}, 32'd0);
        chk("big_busy", {31'd0, o_busy}, 32'd0);
        repeat (3) tick();
        chk("big_no_we", wa.size() - w0, 32'd0);

        // Recover from ERR with a one-word image.
        pulse_start();
        chk("rerr_clr", {31'd0, o_err}, 32'd0);
        img = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef IMEM_LOADER_CHECKSUM_EN
        img.push_back(img_csum(img));
`endif
        send_img(img, 1'b0);
        wait_end();
        chk("rerr_nw", wa.size() - w0, 32'd1);
        chk("rerr_a", wa[w0], 32'h0);
        chk("rerr_d", wd[w0], 32'hDEAD_BEEF);
        chk("rerr_done", {31'd0, o_done}, 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Wrong checksum: the word is written, then ERR.
        w0 = wa.size();
        pulse_start();
        send_img('{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05}, 1'b0);
        wait_end();
        chk("cs_nw", wa.size() - w0, 32'd1);
        chk("cs_d", wd[w0], 32'h0403_0201);
        chk("cs_err", {31'd0, o_err}, 32'd1);
        chk("cs_hold", {31'd0, o_core_hold}, 32'd1);
`endif

        // Reset after the second data byte.
        w0 = wa.size();
        pulse_start();
        send_img('{8'h01, 8'h00, 8'hAA, 8'hBB}, 1'b0);
        i_rst = 1'b1;
        #1;
        chk("mid_hold", {31'd0, o_core_hold}, 32'd1);
        chk("mid_busy", {31'd0, o_busy}, 32'd0);
        chk("mid_ready", {31'd0, o_rx_ready}, 32'd0);
        tick();
        i_rst = 1'b0;
        repeat (3) tick();
        chk("mid_no_we", wa.size() - w0, 32'd0);
        pulse_start();
        img = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
`ifdef IMEM_LOADER_CHECKSUM_EN
        img.push_back(img_csum(img));
`endif
        send_img(img, 1'b0);
        wait_end();
        chk("mid_nw", wa.size() - w0, 32'd1);
        chk("mid_a", wa[w0], 32'h0);
        chk("mid_d", wd[w0], 32'h4433_2211);
        chk("mid_done", {31'd0, o_done}, 32'd1);

        chk("we_vs_ready", nbad, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
